// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues word reads from the upstream PC, buffers in-order responses with their
// fetch PC for decode, flushes on jumps. Optional perf counters under `IFQ_PERF_COUNTERS_EN.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcValue,
  input  logic        jumpEnabled,
  input  logic [31:0] jumpInput,
  output logic        pcHold,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instValid,
  output logic [31:0] instData,
  output logic [31:0] instPc,
  input  logic        decodeReady,
  output logic [15:0] flushCount,
  output logic [15:0] holdCount
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshakes: imemReq is a one-word request taken the cycle it is high (no ready);
  // imemRvalid returns data in request order; decode takes the head when instValid && decodeReady.

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [AW-1:0] q_wptr_q, q_rptr_q;
  logic [AW-1:0] a_wptr_q, a_rptr_q;
  logic [31:0]   q_data_q [DEPTH];
  logic [31:0]   q_pc_q   [DEPTH];
  logic [31:0]   a_addr_q [DEPTH];

  logic credit_ok, issue, rsp, keep, pop;

  // Anything queued or still in flight holds a slot, so a response can never find the queue full.
  assign credit_ok = (count_q + inflight_q) < DEPTH_C;
  assign imemAddr  = {pcValue[31:2], 2'b00};
  assign imemReq   = !reset && !jumpEnabled && credit_ok;
  assign pcHold    = !jumpEnabled && !credit_ok;

  assign instValid = (count_q != '0);
  assign instData  = instValid ? q_data_q[q_rptr_q] : '0;
  assign instPc    = instValid ? q_pc_q[q_rptr_q]   : '0;

  assign issue = imemReq;
  assign rsp   = imemRvalid && (inflight_q != '0);
  assign keep  = rsp && (discard_q == '0) && !jumpEnabled;
  assign pop   = instValid && decodeReady && !jumpEnabled;

  always_comb begin
    inflight_d = inflight_q + CW'(issue) - CW'(rsp);
    count_d    = count_q + CW'(keep) - CW'(pop);
    discard_d  = discard_q;
    if (rsp && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (jumpEnabled) begin
      // Everything still outstanding after this edge belongs to the old stream.
      count_d   = '0;
      discard_d = inflight_q - CW'(rsp);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      q_wptr_q   <= '0;
      q_rptr_q   <= '0;
      a_wptr_q   <= '0;
      a_rptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      if (issue) a_wptr_q <= a_wptr_q + 1'b1;
      if (rsp)   a_rptr_q <= a_rptr_q + 1'b1;
      if (jumpEnabled) begin
        q_wptr_q <= '0;
        q_rptr_q <= '0;
      end else begin
        if (keep) q_wptr_q <= q_wptr_q + 1'b1;
        if (pop)  q_rptr_q <= q_rptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: reads are gated by count/inflight.
  always_ff @(posedge clock) begin
    if (issue) a_addr_q[a_wptr_q] <= imemAddr;
    if (keep) begin
      q_data_q[q_wptr_q] <= imemRdata;
      q_pc_q[q_wptr_q]   <= a_addr_q[a_rptr_q];
    end
  end

`ifdef IFQ_PERF_COUNTERS_EN
  logic [15:0] flush_cnt_q, hold_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      if (jumpEnabled && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (pcHold && (hold_cnt_q != 16'hFFFF))       hold_cnt_q  <= hold_cnt_q + 1'b1;
    end
  end

  assign flushCount = flush_cnt_q;
  assign holdCount  = hold_cnt_q;
`else
  assign flushCount = '0;
  assign holdCount  = '0;
`endif

  // Redirect target and RESET_PC are consumed by the PC stage, not here.
  logic unused_ok;
  assign unused_ok = ^{jumpInput, RESET_PC, pcValue[1:0]};

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: acts as ProgramCounter and an in-order variable-latency memory, and scores
// every cycle against a transaction-level queue model.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pcValue, jumpInput, imemAddr, imemRdata, instData, instPc;
  logic        jumpEnabled, pcHold, imemReq, imemRvalid, instValid, decodeReady;
  logic [15:0] flushCount, holdCount;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .pcValue(pcValue), .jumpEnabled(jumpEnabled),
    .jumpInput(jumpInput), .pcHold(pcHold), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata), .instValid(instValid),
    .instData(instData), .instPc(instPc), .decodeReady(decodeReady),
    .flushCount(flushCount), .holdCount(holdCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference model: delivered-but-unconsumed {pc,data}, and outstanding requests {stale,addr}.
  logic [63:0] exp_q[$];
  logic [32:0] out_q[$];
  logic [31:0] pc_m;
  int          cyc;

  // Memory model.
  logic [31:0] mreq_addr[$];
  int          mreq_due[$];
  int          last_due, lat_lo, lat_hi;
  bit          spurious;

  // Observation trackers for directed scenarios.
  logic [31:0] seen_addr[$];
  logic [31:0] drain_pc[$];
  int          req_cnt, first_req_cyc, first_valid_cyc, first_hold_cyc;
  logic [31:0] first_valid_pc, first_valid_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  function automatic void clear_trackers();
    seen_addr.delete();
    drain_pc.delete();
    req_cnt = 0; first_req_cyc = -1; first_valid_cyc = -1; first_hold_cyc = -1;
    first_valid_pc = '0; first_valid_data = '0;
    cyc = 0;
  endfunction

  task automatic do_reset(input logic [31:0] start_pc);
    @(negedge clock);
    reset = 1'b1;
    pcValue = start_pc; jumpEnabled = 1'b0; jumpInput = '0;
    decodeReady = 1'b1; imemRvalid = 1'b0; imemRdata = '0;
    exp_q.delete(); out_q.delete(); mreq_addr.delete(); mreq_due.delete();
    last_due = -1; spurious = 0; pc_m = start_pc;
    clear_trackers();
    #1;
  endtask

  task automatic step(input logic jump, input logic [31:0] target, input logic ready);
    logic credit, e_req, e_hold, e_valid, rsp;
    logic [31:0] e_addr, e_pc, e_data;
    logic [63:0] head;
    logic [32:0] r;
    int lat, due;
    @(negedge clock);
    reset = 1'b0;
    imemRvalid = 1'b0; imemRdata = '0;
    if (spurious) begin
      imemRvalid = 1'b1; imemRdata = 32'hDEAD_BEEF;
    end else if (mreq_due.size() > 0 && mreq_due[0] <= cyc) begin
      imemRvalid = 1'b1; imemRdata = mem_word(mreq_addr[0]);
      void'(mreq_addr.pop_front()); void'(mreq_due.pop_front());
    end
    pcValue = pc_m; jumpEnabled = jump; jumpInput = target; decodeReady = ready;
    #1;
    credit  = (exp_q.size() + out_q.size()) < DEPTH;
    e_req   = !jump && credit;
    e_hold  = !jump && !credit;
    e_valid = exp_q.size() > 0;
    e_addr  = {pc_m[31:2], 2'b00};
    head    = e_valid ? exp_q[0] : 64'd0;
    e_pc    = head[63:32];
    e_data  = head[31:0];
    checks++; if (imemReq !== e_req) $display("FAIL imemReq cyc=%0d got=%b exp=%b", cyc, imemReq, e_req); else passed++;
    checks++; if (pcHold !== e_hold) $display("FAIL pcHold cyc=%0d got=%b exp=%b", cyc, pcHold, e_hold); else passed++;
    checks++; if (instValid !== e_valid) $display("FAIL instValid cyc=%0d got=%b exp=%b", cyc, instValid, e_valid); else passed++;
    checks++; if (instPc !== e_pc) $display("FAIL instPc cyc=%0d got=%h exp=%h", cyc, instPc, e_pc); else passed++;
    checks++; if (instData !== e_data) $display("FAIL instData cyc=%0d got=%h exp=%h", cyc, instData, e_data); else passed++;
    if (e_req) begin
      checks++; if (imemAddr !== e_addr) $display("FAIL imemAddr cyc=%0d got=%h exp=%h", cyc, imemAddr, e_addr); else passed++;
    end
    // Memory reacts to whatever the DUT actually asked for.
    if (imemReq) begin
      req_cnt++;
      seen_addr.push_back(imemAddr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat - 1;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mreq_addr.push_back(imemAddr);
      mreq_due.push_back(due);
    end
    if (instValid && first_valid_cyc < 0) begin
      first_valid_cyc = cyc; first_valid_pc = instPc; first_valid_data = instData;
    end
    if (instValid && ready && !jump) drain_pc.push_back(instPc);
    if (pcHold && first_hold_cyc < 0) first_hold_cyc = cyc;
    // Advance the model across the clock edge.
    rsp = imemRvalid && (out_q.size() > 0);
    r = '0;
    if (rsp) r = out_q.pop_front();
    if (e_valid && ready && !jump) void'(exp_q.pop_front());
    if (rsp && !r[32] && !jump) exp_q.push_back({r[31:0], mem_word(r[31:0])});
    if (e_req) out_q.push_back({1'b0, e_addr});
    if (jump) begin
      exp_q.delete();
      foreach (out_q[i]) out_q[i][32] = 1'b1;
    end
    pc_m = jump ? target : (e_req ? pc_m + 32'd4 : pc_m);
    cyc++;
  endtask

  task automatic test_reset();
    lat_lo = 2; lat_hi = 2;
    do_reset(RESET_PC);
    step(1'b1, RESET_PC, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    do_reset(RESET_PC);
    checks++; if (instValid !== 1'b0) $display("FAIL rst_instValid got=%b exp=0", instValid); else passed++;
    checks++; if (instData !== 32'd0) $display("FAIL rst_instData got=%h exp=0", instData); else passed++;
    checks++; if (instPc !== 32'd0) $display("FAIL rst_instPc got=%h exp=0", instPc); else passed++;
    checks++; if (imemReq !== 1'b0) $display("FAIL rst_imemReq got=%b exp=0", imemReq); else passed++;
    checks++; if (pcHold !== 1'b0) $display("FAIL rst_pcHold got=%b exp=0", pcHold); else passed++;
    checks++; if (flushCount !== 16'd0) $display("FAIL rst_flushCount got=%0d exp=0", flushCount); else passed++;
    checks++; if (holdCount !== 16'd0) $display("FAIL rst_holdCount got=%0d exp=0", holdCount); else passed++;
  endtask

  task automatic test_startup();
    lat_lo = 2; lat_hi = 2;
    do_reset(RESET_PC);
    repeat (8) step(1'b0, '0, 1'b1);
    checks++; if (seen_addr.size() < 3 || seen_addr[0] !== 32'h3000 || seen_addr[1] !== 32'h3004 || seen_addr[2] !== 32'h3008)
      $display("FAIL startup_addrs got_n=%0d exp=3000,3004,3008", seen_addr.size()); else passed++;
    checks++; if (first_valid_cyc - first_req_cyc != 2)
      $display("FAIL startup_latency got=%0d exp=2", first_valid_cyc - first_req_cyc); else passed++;
    checks++; if (first_valid_pc !== 32'h3000) $display("FAIL startup_pc got=%h exp=00003000", first_valid_pc); else passed++;
    checks++; if (first_valid_data !== mem_word(32'h3000))
      $display("FAIL startup_data got=%h exp=%h", first_valid_data, mem_word(32'h3000)); else passed++;
  endtask

  task automatic test_backpressure();
    lat_lo = 2; lat_hi = 2;
    do_reset(RESET_PC);
    repeat (10) step(1'b0, '0, 1'b0);
    checks++; if (req_cnt != 4) $display("FAIL bp_req_count got=%0d exp=4", req_cnt); else passed++;
    checks++; if (seen_addr.size() != 4 || seen_addr[3] !== 32'h300C)
      $display("FAIL bp_last_addr got_n=%0d exp=4 ending 0000300c", seen_addr.size()); else passed++;
    checks++; if (first_hold_cyc != 4) $display("FAIL bp_hold_start got=%0d exp=4", first_hold_cyc); else passed++;
    // Response with nothing in flight must be ignored.
    spurious = 1;
    step(1'b0, '0, 1'b0);
    spurious = 0;
    repeat (8) step(1'b0, '0, 1'b1);
    checks++; if (drain_pc.size() < 4 || drain_pc[0] !== 32'h3000 || drain_pc[1] !== 32'h3004 ||
                  drain_pc[2] !== 32'h3008 || drain_pc[3] !== 32'h300C)
      $display("FAIL bp_drain_order got_n=%0d exp=3000..300c", drain_pc.size()); else passed++;
  endtask

  task automatic test_flush();
    lat_lo = 4; lat_hi = 4;
    do_reset(RESET_PC);
    repeat (2) step(1'b0, '0, 1'b1);
    clear_trackers();
    step(1'b1, 32'h0000_1240, 1'b1);
    checks++; if (req_cnt != 0) $display("FAIL flush_req_on_jump got=%0d exp=0", req_cnt); else passed++;
    repeat (10) step(1'b0, '0, 1'b1);
    checks++; if (seen_addr.size() == 0 || seen_addr[0] !== 32'h1240)
      $display("FAIL flush_first_addr got_n=%0d exp=00001240", seen_addr.size()); else passed++;
    checks++; if (first_valid_pc !== 32'h1240) $display("FAIL flush_first_pc got=%h exp=00001240", first_valid_pc); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad;
    lat_lo = 2; lat_hi = 2;
    do_reset(RESET_PC);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (12) step(1'b0, '0, 1'b1);
    bad = 0;
    for (int i = 1; i < drain_pc.size(); i++)
      if (drain_pc[i] !== drain_pc[i-1] + 32'd4) bad++;
    checks++; if (bad != 0 || drain_pc.size() < 8)
      $display("FAIL b2b_order got_bad=%0d n=%0d exp=0 bad n>=8", bad, drain_pc.size()); else passed++;
  endtask

  task automatic test_misaligned();
    lat_lo = 2; lat_hi = 3;
    do_reset(32'h0000_3003);
    repeat (6) step(1'b0, '0, 1'b1);
    checks++; if (seen_addr.size() == 0 || seen_addr[0] !== 32'h3000)
      $display("FAIL misalign_addr got_n=%0d exp=00003000", seen_addr.size()); else passed++;
    checks++; if (first_valid_pc !== 32'h3000) $display("FAIL misalign_pc got=%h exp=00003000", first_valid_pc); else passed++;
  endtask

  task automatic test_perf();
    lat_lo = 2; lat_hi = 2;
    do_reset(RESET_PC);
    repeat (9) step(1'b0, '0, 1'b0);
    repeat (3) step(1'b1, 32'h0000_2000, 1'b0);
    @(negedge clock); #1;
`ifdef IFQ_PERF_COUNTERS_EN
    checks++; if (flushCount !== 16'd3) $display("FAIL perf_flush got=%0d exp=3", flushCount); else passed++;
    checks++; if (holdCount !== 16'd5) $display("FAIL perf_hold got=%0d exp=5", holdCount); else passed++;
`else
    checks++; if (flushCount !== 16'd0) $display("FAIL perf_flush got=%0d exp=0", flushCount); else passed++;
    checks++; if (holdCount !== 16'd0) $display("FAIL perf_hold got=%0d exp=0", holdCount); else passed++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    lat_lo = 2; lat_hi = 5;
    do_reset(RESET_PC);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(32'hFFFF_FFF0);
      spurious = (out_q.size() == 0) && (mreq_due.size() == 0) && ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom();
      step(($urandom_range(0, 15) == 0), tgt, ($urandom_range(0, 3) != 0));
      spurious = 0;
    end
  endtask

  initial begin
    reset = 1'b1; pcValue = RESET_PC; jumpEnabled = 1'b0; jumpInput = '0;
    imemRvalid = 1'b0; imemRdata = '0; decodeReady = 1'b0;
    lat_lo = 2; lat_hi = 2; spurious = 0; last_due = -1; pc_m = RESET_PC;
    clear_trackers();
    test_reset();
    test_startup();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_misaligned();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
